// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the 16-bit WISC core.
// Holds the PC, issues one outstanding instruction-memory read at a time,
// buffers one instruction for the decoder, accepts branch/jump redirects and
// pre-decodes HALT (opcode 5'b00000) so fetching stops cleanly.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   imem_req/addr      read request and (even) address to instruction memory
//   imem_ready/rdata   memory response strobe and instruction word
//   instr, pc_plus2    buffered instruction and its address + 2
//   instr_valid        buffer holds a valid instruction
//   instr_ready        decoder consumes the buffer this cycle
//   redirect/_pc       taken branch/jump pulse and its target
//   halted             HALT consumed; fetch stopped until reset
//   err                one-cycle pulse when a redirect target was odd
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic [15:0] pc_plus2,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN,
    HALTED
  } state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n, pc_inc;
  logic [15:0] addr_n, instr_n, pc2_n;
  logic        valid_n, halted_n, err_n;
  logic        launch, req;

  assign launch   = ~instr_valid | instr_ready;
  assign req      = (state == WAIT) | (state == DRAIN) | ((state == IDLE) & launch);
  assign imem_req = req & ~rst;
  assign pc_inc   = pc + 16'd2;

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    addr_n   = imem_addr;
    instr_n  = instr;
    pc2_n    = pc_plus2;
    valid_n  = instr_valid;
    halted_n = halted;
    err_n    = 1'b0;

    if (halted) begin
      // Fully stopped: redirects ignored, pc frozen until reset.
      state_n = HALTED;
    end else if (redirect) begin
      pc_n    = redirect_pc & 16'hFFFE;
      err_n   = redirect_pc[0];
      valid_n = 1'b0;
      instr_n = NOP_INSTR;
      unique case (state)
        WAIT, DRAIN: state_n = imem_ready ? IDLE : DRAIN;
        // A request launched this very cycle is outstanding unless it completed.
        IDLE:        state_n = (launch & ~imem_ready) ? DRAIN : IDLE;
        HALTED:      state_n = IDLE;
        default:     state_n = IDLE;
      endcase
    end else if (req & imem_ready & (state != DRAIN)) begin
      instr_n = imem_rdata;
      pc2_n   = pc_inc;
      pc_n    = pc_inc;
      valid_n = 1'b1;
      state_n = (imem_rdata[15:11] == 5'b00000) ? HALTED : IDLE;
    end else begin
      if ((state == DRAIN) & imem_ready) begin
        state_n = IDLE;
      end
      if ((state == IDLE) & req & ~imem_ready) begin
        state_n = WAIT;
      end
      if (instr_valid & instr_ready) begin
        valid_n = 1'b0;
        instr_n = NOP_INSTR;
        if (state == HALTED) begin
          halted_n = 1'b1;
        end
      end
    end

    // The address register tracks pc only while no request is outstanding,
    // so a redirect during WAIT/DRAIN leaves the old request's address stable.
    if ((state_n == IDLE) | (state_n == HALTED)) begin
      addr_n = pc_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_addr   <= RESET_PC;
      instr       <= NOP_INSTR;
      pc_plus2    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      imem_addr   <= addr_n;
      instr       <= instr_n;
      pc_plus2    <= pc2_n;
      instr_valid <= valid_n;
      halted      <= halted_n;
      err         <= err_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: table-driven streaming vectors, directed
// multi-cycle corner cases, and a randomized run against a stream-level
// reference model (the decoder must see mem[pc], mem[pc+2], ... restarting
// at every redirect target).
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [15:0] pc_plus2;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [15:0] tab [16];
  logic        hash_mode = 1'b0;
  logic        rand_lat  = 1'b0;
  int unsigned lat_fixed = 0;
  int unsigned rlat;
  int unsigned cnt;
  int unsigned hs_cnt = 0;

  fetch_unit #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .pc_plus2(pc_plus2), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] hashw(input logic [15:0] a);
    return 16'h8000 | (a ^ 16'h1357);
  endfunction

  // Memory model: response after a (fixed or random) number of wait cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 0;
      rlat <= 0;
    end else if (!imem_req || imem_ready) begin
      cnt <= 0;
      if (imem_ready) begin
        rlat   <= $urandom_range(0, 3);
        hs_cnt <= hs_cnt + 1;
      end
    end else begin
      cnt <= cnt + 1;
    end
  end

  assign imem_ready = imem_req && (cnt >= (rand_lat ? rlat : lat_fixed));

  always_comb begin
    if (!hash_mode && imem_addr < 16'h0020) imem_rdata = tab[imem_addr[4:1]];
    else                                    imem_rdata = hashw(imem_addr);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic init_tab();
    for (int i = 0; i < 16; i++) tab[i] = 16'h4001 + 16'(i);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20 && !instr_valid; i++) step();
    chk({name, "_timeout"}, {15'd0, instr_valid}, 16'd1);
  endtask

  typedef struct {
    logic        rdy;
    logic        ev;
    logic [15:0] ei;
    logic [15:0] ep2;
    logic        ereq;
    logic [15:0] eaddr;
  } vec_t;

  vec_t vt [9];

  logic [15:0] exp_pc, tgt, prev_addr;
  logic        exp_err, prev_hold, do_redir;
  int          consumed, h0;

  initial begin
    init_tab();

    // Zero-wait streaming with decoder stalls.
    vt[0] = '{1'b1, 1'b0, 16'h0800, 16'h0000, 1'b1, 16'h0000};
    vt[1] = '{1'b1, 1'b1, 16'h4001, 16'h0002, 1'b1, 16'h0002};
    vt[2] = '{1'b0, 1'b1, 16'h4002, 16'h0004, 1'b0, 16'h0004};
    vt[3] = '{1'b1, 1'b1, 16'h4002, 16'h0004, 1'b1, 16'h0004};
    vt[4] = '{1'b1, 1'b1, 16'h4003, 16'h0006, 1'b1, 16'h0006};
    vt[5] = '{1'b0, 1'b1, 16'h4004, 16'h0008, 1'b0, 16'h0008};
    vt[6] = '{1'b0, 1'b1, 16'h4004, 16'h0008, 1'b0, 16'h0008};
    vt[7] = '{1'b1, 1'b1, 16'h4004, 16'h0008, 1'b1, 16'h0008};
    vt[8] = '{1'b1, 1'b1, 16'h4005, 16'h000A, 1'b1, 16'h000A};

    lat_fixed = 0;
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    @(negedge clk);
    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc2", pc_plus2, 16'h0000);
    chk("rst_req", {15'd0, imem_req}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    do_reset();

    for (int i = 0; i < 9; i++) begin
      chk($sformatf("tab%0d_valid", i), {15'd0, instr_valid}, {15'd0, vt[i].ev});
      chk($sformatf("tab%0d_instr", i), instr, vt[i].ei);
      chk($sformatf("tab%0d_pc2", i), pc_plus2, vt[i].ep2);
      instr_ready = vt[i].rdy;
      #1;
      chk($sformatf("tab%0d_req", i), {15'd0, imem_req}, {15'd0, vt[i].ereq});
      chk($sformatf("tab%0d_addr", i), imem_addr, vt[i].eaddr);
      step();
    end

    // Two-cycle memory latency with a stalled decoder.
    lat_fixed = 2;
    do_reset();
    instr_ready = 1'b0;
    #1 chk("lat2_req0", {15'd0, imem_req}, 16'd1);
    chk("lat2_addr0", imem_addr, 16'h0000);
    step();
    chk("lat2_wait_valid", {15'd0, instr_valid}, 16'd0);
    chk("lat2_wait_req", {15'd0, imem_req}, 16'd1);
    step();
    chk("lat2_ready", {15'd0, imem_ready}, 16'd1);
    step();
    chk("lat2_valid", {15'd0, instr_valid}, 16'd1);
    chk("lat2_instr", instr, 16'h4001);
    chk("lat2_pc2", pc_plus2, 16'h0002);
    chk("lat2_noreq_a", {15'd0, imem_req}, 16'd0);
    h0 = hs_cnt;
    step();
    chk("lat2_hold_a", instr, 16'h4001);
    chk("lat2_noreq_b", {15'd0, imem_req}, 16'd0);
    step();
    chk("lat2_hold_b", instr, 16'h4001);
    chk("lat2_noreq_c", {15'd0, imem_req}, 16'd0);
    chk("lat2_one_req", 16'(hs_cnt - h0), 16'd0);
    instr_ready = 1'b1;
    #1 chk("lat2_relaunch", {15'd0, imem_req}, 16'd1);
    chk("lat2_addr2", imem_addr, 16'h0002);
    step();
    chk("lat2_consumed", {15'd0, instr_valid}, 16'd0);
    chk("lat2_nop", instr, NOP);
    wait_valid("lat2");
    chk("lat2_next", instr, 16'h4002);
    chk("lat2_next_pc2", pc_plus2, 16'h0004);

    // Redirect while a request is outstanding: old data discarded.
    do_reset();
    instr_ready = 1'b1;
    #1 chk("rd_req", {15'd0, imem_req}, 16'd1);
    step();
    redirect = 1'b1;
    redirect_pc = 16'h0100;
    #1 chk("rd_notready", {15'd0, imem_ready}, 16'd0);
    step();
    redirect = 1'b0;
    chk("rd_drain_valid", {15'd0, instr_valid}, 16'd0);
    chk("rd_drain_req", {15'd0, imem_req}, 16'd1);
    chk("rd_drain_addr", imem_addr, 16'h0000);
    chk("rd_drain_ready", {15'd0, imem_ready}, 16'd1);
    step();
    chk("rd_after_valid", {15'd0, instr_valid}, 16'd0);
    chk("rd_after_instr", instr, NOP);
    chk("rd_new_req", {15'd0, imem_req}, 16'd1);
    chk("rd_new_addr", imem_addr, 16'h0100);
    chk("rd_err", {15'd0, err}, 16'd0);
    wait_valid("rd");
    chk("rd_instr", instr, hashw(16'h0100));
    chk("rd_pc2", pc_plus2, 16'h0102);

    // Odd redirect target.
    lat_fixed = 0;
    do_reset();
    instr_ready = 1'b1;
    step();
    chk("odd_pre", instr, 16'h4001);
    redirect = 1'b1;
    redirect_pc = 16'h0033;
    step();
    redirect = 1'b0;
    chk("odd_err", {15'd0, err}, 16'd1);
    chk("odd_flush", {15'd0, instr_valid}, 16'd0);
    chk("odd_addr", imem_addr, 16'h0032);
    #1 chk("odd_req", {15'd0, imem_req}, 16'd1);
    step();
    chk("odd_err_clr", {15'd0, err}, 16'd0);
    chk("odd_valid", {15'd0, instr_valid}, 16'd1);
    chk("odd_instr", instr, hashw(16'h0032));
    chk("odd_pc2", pc_plus2, 16'h0034);

    // HALT fetched at address 4.
    tab[2] = 16'h0000;
    do_reset();
    instr_ready = 1'b1;
    step();
    chk("halt_i0", instr, 16'h4001);
    step();
    chk("halt_i1", instr, 16'h4002);
    chk("halt_addr4", imem_addr, 16'h0004);
    step();
    chk("halt_instr", instr, 16'h0000);
    chk("halt_valid", {15'd0, instr_valid}, 16'd1);
    chk("halt_pc2", pc_plus2, 16'h0006);
    instr_ready = 1'b0;
    #1 chk("halt_noreq_a", {15'd0, imem_req}, 16'd0);
    step();
    chk("halt_held", {15'd0, instr_valid}, 16'd1);
    chk("halt_not_yet", {15'd0, halted}, 16'd0);
    chk("halt_noreq_b", {15'd0, imem_req}, 16'd0);
    instr_ready = 1'b1;
    step();
    chk("halt_consumed", {15'd0, instr_valid}, 16'd0);
    chk("halt_flag", {15'd0, halted}, 16'd1);
    chk("halt_nop", instr, NOP);
    redirect = 1'b1;
    redirect_pc = 16'h0041;
    #1 chk("halt_noreq_c", {15'd0, imem_req}, 16'd0);
    step();
    redirect = 1'b0;
    chk("halt_no_err", {15'd0, err}, 16'd0);
    chk("halt_stays", {15'd0, halted}, 16'd1);
    chk("halt_noreq_d", {15'd0, imem_req}, 16'd0);
    chk("halt_pc_frozen", imem_addr, 16'h0006);
    step();
    chk("halt_noreq_e", {15'd0, imem_req}, 16'd0);
    chk("halt_pc_frozen2", imem_addr, 16'h0006);
    init_tab();

    // PC wrap at 0xFFFE.
    do_reset();
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    chk("wrap_addr", imem_addr, 16'hFFFE);
    step();
    chk("wrap_instr", instr, hashw(16'hFFFE));
    chk("wrap_pc2", pc_plus2, 16'h0000);
    chk("wrap_next_addr", imem_addr, 16'h0000);

    // Reset asserted while a request is outstanding.
    do_reset();
    instr_ready = 1'b1;
    repeat (3) step();
    lat_fixed = 5;
    step();
    chk("mid_wait_req", {15'd0, imem_req}, 16'd1);
    chk("mid_wait_pc2", pc_plus2, 16'h0006);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {15'd0, imem_req}, 16'd0);
    chk("mid_rst_addr", imem_addr, 16'h0000);
    chk("mid_rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("mid_rst_instr", instr, NOP);
    chk("mid_rst_pc2", pc_plus2, 16'h0000);
    chk("mid_rst_halted", {15'd0, halted}, 16'd0);
    chk("mid_rst_err", {15'd0, err}, 16'd0);

    // Randomized run against the instruction-stream model.
    hash_mode = 1'b1;
    rand_lat  = 1'b1;
    do_reset();
    exp_pc    = 16'h0000;
    exp_err   = 1'b0;
    prev_hold = 1'b0;
    prev_addr = '0;
    consumed  = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_err", {15'd0, err}, {15'd0, exp_err});
      if (!instr_valid) chk("rnd_nop", instr, NOP);
      chk("rnd_even", {15'd0, imem_addr[0]}, 16'd0);
      instr_ready = ($urandom % 10) < 7;
      do_redir    = ($urandom % 25) == 0;
      tgt         = 16'($urandom);
      redirect    = do_redir;
      redirect_pc = tgt;
      #1;
      if (prev_hold) begin
        chk("rnd_req_stable", {15'd0, imem_req}, 16'd1);
        chk("rnd_addr_stable", imem_addr, prev_addr);
      end
      if (instr_valid && instr_ready) begin
        chk("rnd_instr", instr, hashw(exp_pc));
        chk("rnd_pc2", pc_plus2, exp_pc + 16'd2);
        exp_pc = exp_pc + 16'd2;
        consumed++;
      end
      if (do_redir) exp_pc = tgt & 16'hFFFE;
      exp_err   = do_redir & tgt[0];
      prev_hold = imem_req & ~imem_ready;
      prev_addr = imem_addr;
      step();
    end
    redirect = 1'b0;
    chk("rnd_progress", {15'd0, consumed > 200}, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
